reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-port register file for the mips_32 core: one write port, NUM_RD read ports.
//  Reads are synchronous with 1-cycle latency, like the existing RAM-based file.
//  Adds write-to-read bypass, an optional hardwired-zero register 0 and a self-clearing reset sequence.
//  Sits between decode (read addresses) and writeback (write port).
// PARAMETERS
//  DATA_W          32  register width in bits
//  ADDR_W          5   address width; DEPTH = 2**ADDR_W registers
//  NUM_RD          2   number of independent read ports (>=1)
//  ZERO_REG        1   1: register 0 reads as 0 and ignores writes
//  CLEAR_ON_RESET  1   1: after reset, walk all addresses writing 0; 0: no clear sequence
// PORTS
//  clk          in   1               rising-edge clock
//  rst_n        in   1               synchronous active-low reset
//  wren         in   1               write enable
//  wraddress    in   ADDR_W          write address
//  data         in   DATA_W          write data
//  rden         in   NUM_RD          per-port read enable; bit i serves port i
//  rdaddress    in   NUM_RD*ADDR_W   port i address at [i*ADDR_W +: ADDR_W]
//  q            out  NUM_RD*DATA_W   port i data at [i*DATA_W +: DATA_W], registered
//  ready        out  1               1 = clear sequence done, file accepts traffic
// BEHAVIOUR
//  Reset: any rising edge with rst_n=0 sets q=0, ready=0, clr_ptr=0 and state=CLEAR.
//   - If CLEAR_ON_RESET=0, state=RUN instead.
//   - rst_n is sampled only at clk edges; there is no asynchronous path.
//  FSM state CLEAR:
//   - Each edge with rst_n=1 writes mem[clr_ptr]=0, then clr_ptr++.
//   - The edge that writes DEPTH-1 moves state to RUN and sets ready=1.
//   - ready therefore rises at the DEPTH-th edge after rst_n is released.
//   - wren and rden are ignored; q holds 0.
//  FSM state RUN:
//   - ready=1.
//   - With CLEAR_ON_RESET=0, ready=1 from the first edge with rst_n=1.
//   - Stays in RUN until the next reset.
//  Write:
//   - In RUN, wren=1 stores data at mem[wraddress] on the edge.
//   - With ZERO_REG=1 and wraddress=0, the write is dropped.
//  Read port i:
//   - In RUN, on an edge with rden[i]=1, q_i <= mem[rdaddress_i]; latency 1 cycle.
//   - With rden[i]=0, q_i holds its previous value.
//  Bypass:
//   - Condition: same edge has wren=1, rden[i]=1 and wraddress==rdaddress_i.
//   - Then q_i <= data, the new value (write-first).
//   - Not applied to address 0 when ZERO_REG=1.
//  Zero register: with ZERO_REG=1, rdaddress_i=0 and rden[i]=1 give q_i <= 0, including the bypass case.
//  Multiple ports may read the same address in the same cycle; each gets an identical result.
//  Reset mid-operation (CLEAR or RUN):
//   - Restarts CLEAR from clr_ptr=0.
//   - Previous contents are lost once the walk passes them.
//   - A write presented on the reset edge is discarded.
//  Contents before the first reset are undefined when CLEAR_ON_RESET=0.
//  No wrap: clr_ptr stops at DEPTH-1. Addresses are always in range, so no out-of-range case exists.
// TESTING (defaults: DATA_W=32, ADDR_W=5, NUM_RD=2)
//  1 Clear: rst_n=0 for 2 edges, then 1.
//    -> ready=0 for 31 edges and 1 at the 32nd edge.
//    -> Reading all 32 addresses on both ports returns 0.
//  2 Write/read: write 0xDEADBEEF to reg 5; next cycle rden=2'b01, port0 address 5.
//    -> q_0=0xDEADBEEF one edge later.
//    -> q_1 is unchanged.
//  3 Bypass: in one cycle write 0x12345678 to reg 7 while both ports read 7.
//    -> After that edge, q_0=q_1=0x12345678.
//  4 Zero reg: write 0xFFFFFFFF to reg 0, plus a same-cycle read of 0 on port 1.
//    -> q_1=0 on that edge and on every later read of reg 0.
//  5 Hold: load q_1=0xA5A5A5A5, then rden[1]=0 while rdaddress_1 sweeps 1..31.
//    -> q_1 stays 0xA5A5A5A5 throughout.
//  6 Mid-run reset: write 0x1 to regs 1..3, pulse rst_n low 1 cycle, write reg 2 during CLEAR.
//    -> ready drops and returns after 32 edges.
//    -> Regs 1..3 read as 0.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port register file: one write port, NUM_RD synchronous read ports with
// write-first bypass, optional hardwired zero register and a post-reset clear walk.
module reg_file_mp #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned NUM_RD         = 2,
  parameter int unsigned ZERO_REG       = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wren,
  input  logic [ADDR_W-1:0]          wraddress,
  input  logic [DATA_W-1:0]          data,
  input  logic [NUM_RD-1:0]          rden,
  input  logic [NUM_RD*ADDR_W-1:0]   rdaddress,
  output logic [NUM_RD*DATA_W-1:0]   q,
  output logic                       ready
);

  localparam int unsigned        DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0]  LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                    state, state_d;
  logic [ADDR_W-1:0]         clr_ptr, clr_ptr_d;
  logic                      ready_d;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_wa;
  logic [DATA_W-1:0]         mem_wd;
  logic [NUM_RD*DATA_W-1:0]  q_d;
  logic [ADDR_W-1:0]         rd_addr [NUM_RD];
  logic [DATA_W-1:0]         mem [DEPTH];

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_addr
    assign rd_addr[g] = rdaddress[g*ADDR_W +: ADDR_W];
  end

  // Next-state and write-port steering: the clear walk owns the write port until RUN.
  always_comb begin
    state_d   = state;
    clr_ptr_d = clr_ptr;
    ready_d   = ready;
    mem_we    = 1'b0;
    mem_wa    = wraddress;
    mem_wd    = data;
    case (state)
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = clr_ptr;
        mem_wd = '0;
        if (clr_ptr == LAST) begin
          state_d = RUN;
          ready_d = 1'b1;
        end else begin
          clr_ptr_d = clr_ptr + ADDR_W'(1);
        end
      end
      RUN: begin
        ready_d = 1'b1;
        mem_we  = wren && !((ZERO_REG != 0) && (wraddress == '0));
      end
      default: state_d = RUN;
    endcase
  end

  // Read ports: zero register first, then same-edge write bypass, else array.
  always_comb begin
    q_d = q;
    if (state == RUN) begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (rden[i]) begin
          if ((ZERO_REG != 0) && (rd_addr[i] == '0)) begin
            q_d[i*DATA_W +: DATA_W] = '0;
          end else if (wren && (wraddress == rd_addr[i])) begin
            q_d[i*DATA_W +: DATA_W] = data;
          end else begin
            q_d[i*DATA_W +: DATA_W] = mem[rd_addr[i]];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_ptr <= '0;
      ready   <= 1'b0;
      q       <= '0;
    end else begin
      state   <= state_d;
      clr_ptr <= clr_ptr_d;
      ready   <= ready_d;
      q       <= q_d;
    end
  end

  // Storage has no reset; writes on a reset edge are dropped.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus randomized traffic
// compared against a behavioural array model.
module tb_reg_file_mp;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wren;
  logic [AW-1:0]     wraddress;
  logic [DW-1:0]     data;
  logic [NR-1:0]     rden;
  logic [NR*AW-1:0]  rdaddress;
  logic [NR*DW-1:0]  q;
  logic              ready;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] q_m   [NR];
  logic          ready_m;
  int            since;

  reg_file_mp dut (
    .clk(clk), .rst_n(rst_n), .wren(wren), .wraddress(wraddress), .data(data),
    .rden(rden), .rdaddress(rdaddress), .q(q), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic set_rd(input int port, input logic [AW-1:0] a);
    rdaddress[port*AW +: AW] = a;
  endtask

  // Advance one clock edge, updating the model from the inputs presented to it.
  task automatic tick();
    logic [DW-1:0] nq [NR];
    logic [AW-1:0] a;
    nq = q_m;
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) nq[i] = '0;
      ready_m = 1'b0;
      since   = 0;
    end else if (since < int'(DEPTH)) begin
      since++;
      if (since == int'(DEPTH)) begin
        ready_m = 1'b1;
        for (int k = 0; k < int'(DEPTH); k++) mem_m[k] = '0;
      end
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (rden[i]) begin
          a = rdaddress[i*AW +: AW];
          if (a == 0)                            nq[i] = '0;
          else if (wren && wraddress == a)       nq[i] = data;
          else                                   nq[i] = mem_m[a];
        end
      end
      if (wren && wraddress != 0) mem_m[wraddress] = data;
      ready_m = 1'b1;
    end
    q_m = nq;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wren = 1'b0; rden = '0; wraddress = '0; data = '0; rdaddress = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle();
    tick(); tick();
    total++;
    if (q !== '0 || ready !== 1'b0) begin
      bad++; $display("FAIL reset_state: q=%h ready=%b want q=0 ready=0", q, ready);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 31; e++) begin
      wren = 1'b1; wraddress = AW'(e); data = 32'hFFFF_0000 | DW'(e); rden = 2'b11;
      tick();
      total++;
      if (ready !== 1'b0) begin
        bad++; $display("FAIL clear_ready_low edge %0d: got %b want 0", e, ready);
      end
      total++;
      if (q !== '0) begin
        bad++; $display("FAIL clear_q_hold edge %0d: got %h want 0", e, q);
      end
    end
    idle();
    tick();
    total++;
    if (ready !== 1'b1) begin
      bad++; $display("FAIL clear_ready_high edge 32: got %b want 1", ready);
    end
    for (int a = 0; a < int'(DEPTH); a++) begin
      rden = 2'b11; set_rd(0, AW'(a)); set_rd(1, AW'(31 - a));
      tick();
      total++;
      if (q[0 +: DW] !== '0 || q[DW +: DW] !== '0) begin
        bad++; $display("FAIL clear_read addr %0d: got %h want 0", a, q);
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    wren = 1'b1; wraddress = 5'd5; data = 32'hDEAD_BEEF; rden = 2'b00;
    tick();
    wren = 1'b0; rden = 2'b01; set_rd(0, 5'd5); set_rd(1, 5'd9);
    tick();
    total++;
    if (q[0 +: DW] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL write_read_q0: got %h want deadbeef", q[0 +: DW]);
    end
    total++;
    if (q[DW +: DW] !== q_m[1]) begin
      bad++; $display("FAIL write_read_q1_hold: got %h want %h", q[DW +: DW], q_m[1]);
    end
    idle();
  endtask

  task automatic test_bypass();
    wren = 1'b1; wraddress = 5'd7; data = 32'h1234_5678;
    rden = 2'b11; set_rd(0, 5'd7); set_rd(1, 5'd7);
    tick();
    total++;
    if (q[0 +: DW] !== 32'h1234_5678 || q[DW +: DW] !== 32'h1234_5678) begin
      bad++; $display("FAIL bypass: got %h want 12345678 on both ports", q);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    wren = 1'b1; wraddress = 5'd0; data = 32'hFFFF_FFFF;
    rden = 2'b10; set_rd(1, 5'd0); set_rd(0, 5'd3);
    tick();
    total++;
    if (q[DW +: DW] !== '0) begin
      bad++; $display("FAIL zero_bypass: got %h want 0", q[DW +: DW]);
    end
    wren = 1'b0; rden = 2'b11; set_rd(0, 5'd0); set_rd(1, 5'd0);
    tick();
    total++;
    if (q !== '0) begin
      bad++; $display("FAIL zero_read: got %h want 0", q);
    end
    idle();
  endtask

  task automatic test_hold();
    wren = 1'b1; wraddress = 5'd9; data = 32'hA5A5_A5A5; rden = '0;
    tick();
    wren = 1'b0; rden = 2'b10; set_rd(1, 5'd9);
    tick();
    for (int a = 1; a <= 31; a++) begin
      rden = {1'b0, 1'($urandom)}; set_rd(1, AW'(a)); set_rd(0, AW'($urandom_range(0, 31)));
      wren = 1'($urandom); wraddress = AW'($urandom_range(10, 31)); data = $urandom;
      tick();
      total++;
      if (q[DW +: DW] !== 32'hA5A5_A5A5) begin
        bad++; $display("FAIL hold_q1 addr %0d: got %h want a5a5a5a5", a, q[DW +: DW]);
      end
      total++;
      if (q[0 +: DW] !== q_m[0]) begin
        bad++; $display("FAIL hold_q0 addr %0d: got %h want %h", a, q[0 +: DW], q_m[0]);
      end
    end
    idle();
  endtask

  task automatic test_mid_reset();
    for (int r = 1; r <= 3; r++) begin
      wren = 1'b1; wraddress = AW'(r); data = 32'h1; rden = '0;
      tick();
    end
    wren = 1'b0; rden = 2'b11; set_rd(0, 5'd1); set_rd(1, 5'd3);
    tick();
    total++;
    if (q[0 +: DW] !== 32'h1 || q[DW +: DW] !== 32'h1) begin
      bad++; $display("FAIL mid_pre_read: got %h want 1 on both ports", q);
    end
    rst_n = 1'b0; wren = 1'b1; wraddress = 5'd1; data = 32'hBAD0_BAD0;
    tick();
    total++;
    if (ready !== 1'b0 || q !== '0) begin
      bad++; $display("FAIL mid_reset_state: ready=%b q=%h want 0/0", ready, q);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 31; e++) begin
      wren = (e <= 3); wraddress = 5'd2; data = 32'h7777_7777;
      tick();
      total++;
      if (ready !== 1'b0) begin
        bad++; $display("FAIL mid_ready_low edge %0d: got %b want 0", e, ready);
      end
    end
    idle();
    tick();
    total++;
    if (ready !== 1'b1) begin
      bad++; $display("FAIL mid_ready_high edge 32: got %b want 1", ready);
    end
    for (int r = 1; r <= 3; r++) begin
      rden = 2'b11; set_rd(0, AW'(r)); set_rd(1, AW'(r));
      tick();
      total++;
      if (q !== '0) begin
        bad++; $display("FAIL mid_cleared reg %0d: got %h want 0", r, q);
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wren = 1'($urandom);
      data = $urandom;
      rden = NR'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        wraddress = AW'($urandom_range(0, 3));
        set_rd(0, AW'($urandom_range(0, 3)));
        set_rd(1, AW'($urandom_range(0, 3)));
      end else begin
        wraddress = AW'($urandom);
        set_rd(0, AW'($urandom));
        set_rd(1, AW'($urandom));
      end
      tick();
      for (int i = 0; i < NR; i++) begin
        total++;
        if (q[i*DW +: DW] !== q_m[i]) begin
          bad++; $display("FAIL rand_q%0d cycle %0d: got %h want %h", i, c, q[i*DW +: DW], q_m[i]);
        end
      end
      total++;
      if (ready !== ready_m) begin
        bad++; $display("FAIL rand_ready cycle %0d: got %b want %b", c, ready, ready_m);
      end
    end
    idle();
  endtask

  initial begin
    since   = 0;
    ready_m = 1'b0;
    for (int i = 0; i < NR; i++) q_m[i] = '0;
    for (int k = 0; k < int'(DEPTH); k++) mem_m[k] = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_hold();
    test_random();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
